// File: rtl/ram_latency_responder.sv
// Behavioural RAM end of the cpu_ram_if handshake: single-word read/write
// answered with ACCESS after LAT wait-state cycles. Array contents survive reset.
module ram_latency_responder #(
   parameter int LAT    = 2,
   parameter int ADDR_W = 10
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] memaddr,
   input  logic [31:0] memstore,
   input  logic        memREN,
   input  logic        memWEN,
   output logic [31:0] ramload,
   output logic [1:0]  ramstate
);

   typedef enum logic [1:0] {
      FREE   = 2'b00,
      BUSY   = 2'b01,
      ACCESS = 2'b10,
      ERROR  = 2'b11
   } ram_state_t;

   localparam logic [3:0] LAT4 = 4'(LAT);

   logic [31:0]       mem [2**ADDR_W];
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] l_addr;
   logic              l_ren, l_wen;

   logic [ADDR_W-1:0] word;
   logic              req, match, oor;
   logic [3:0]        eff;
   ram_state_t        state;

   assign word  = memaddr[ADDR_W+1:2];
   assign req   = memREN | memWEN;
   assign match = req && (l_addr == word) && (l_ren == memREN) && (l_wen == memWEN);
   assign eff   = match ? cnt : 4'd0;
   assign oor   = |memaddr[31:ADDR_W+2];

   always_comb begin
      state = BUSY;
      if (memREN && memWEN)  state = ERROR;
      else if (req && oor)   state = ERROR;
      else if (!req)         state = FREE;
      else if (eff == LAT4)  state = ACCESS;
   end

   assign ramstate = state;
   assign ramload  = (state == ACCESS && memREN) ? mem[word] : 32'h0;

   // Only BUSY advances the count; every other state ends or aborts the transfer.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt    <= 4'd0;
         l_addr <= '0;
         l_ren  <= 1'b0;
         l_wen  <= 1'b0;
      end else if (state == BUSY) begin
         cnt    <= eff + 4'd1;
         l_addr <= word;
         l_ren  <= memREN;
         l_wen  <= memWEN;
      end else begin
         cnt    <= 4'd0;
         l_addr <= '0;
         l_ren  <= 1'b0;
         l_wen  <= 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST && state == ACCESS && memWEN)
         mem[word] <= memstore;
   end

endmodule

// File: tb/tb_ram_latency_responder.sv
// Directed bench: one LAT=2 and one LAT=0 responder, expectations queued per cycle.
module tb_ram_latency_responder;

   localparam logic [1:0] FREE = 2'b00, BUSY = 2'b01, ACCESS = 2'b10, ERROR = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] addr2, data2, addr0, data0;
   logic        ren2, wen2, ren0, wen0;
   logic [31:0] load2, load0;
   logic [1:0]  state2, state0;

   typedef struct {
      logic [1:0]  st;
      logic [31:0] ld;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   ram_latency_responder #(.LAT(2), .ADDR_W(10)) dut2 (
      .CLK(clk), .RST(rst), .memaddr(addr2), .memstore(data2),
      .memREN(ren2), .memWEN(wen2), .ramload(load2), .ramstate(state2));

   ram_latency_responder #(.LAT(0), .ADDR_W(10)) dut0 (
      .CLK(clk), .RST(rst), .memaddr(addr0), .memstore(data0),
      .memREN(ren0), .memWEN(wen0), .ramload(load0), .ramstate(state0));

   // Drive one cycle on the selected instance, check its outputs mid-cycle.
   task automatic step(input bit sel0, input logic r, input logic ren, input logic wen,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] est, input logic [31:0] eld, input string tag);
      exp_t e;
      logic [1:0]  ost;
      logic [31:0] old;
      rst = r;
      if (sel0) begin ren0 = ren; wen0 = wen; addr0 = a; data0 = d; end
      else      begin ren2 = ren; wen2 = wen; addr2 = a; data2 = d; end
      e.st = est; e.ld = eld; e.tag = tag;
      sb.push_back(e);
      @(negedge clk);
      ost = sel0 ? state0 : state2;
      old = sel0 ? load0 : load2;
      e = sb.pop_front();
      tests++;
      assert (ost === e.st) else begin
         fails++;
         $error("FAIL %s ramstate: got %b expected %b", e.tag, ost, e.st);
      end
      tests++;
      assert (old === e.ld) else begin
         fails++;
         $error("FAIL %s ramload: got %h expected %h", e.tag, old, e.ld);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic s2(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] est, input logic [31:0] eld, input string tag);
      step(1'b0, 1'b0, ren, wen, a, d, est, eld, tag);
   endtask

   task automatic idle2(input string tag);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, tag);
   endtask

   task automatic wr2(input logic [31:0] a, input logic [31:0] d, input string tag);
      s2(1'b0, 1'b1, a, d, BUSY, 32'h0, {tag, "_b1"});
      s2(1'b0, 1'b1, a, d, BUSY, 32'h0, {tag, "_b2"});
      s2(1'b0, 1'b1, a, d, ACCESS, 32'h0, {tag, "_acc"});
      idle2({tag, "_idle"});
   endtask

   task automatic rd2(input logic [31:0] a, input logic [31:0] d, input string tag);
      s2(1'b1, 1'b0, a, 32'h0, BUSY, 32'h0, {tag, "_b1"});
      s2(1'b1, 1'b0, a, 32'h0, BUSY, 32'h0, {tag, "_b2"});
      s2(1'b1, 1'b0, a, 32'h0, ACCESS, d, {tag, "_acc"});
      idle2({tag, "_idle"});
   endtask

   initial begin
      rst = 1'b1;
      ren2 = 0; wen2 = 0; addr2 = 0; data2 = 0;
      ren0 = 0; wen0 = 0; addr0 = 0; data0 = 0;

      // reset and idle
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "rst_free");
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "rst_free0");
      repeat (3) idle2("idle_free");

      // basic write then read
      wr2(32'h40, 32'hDEADBEEF, "wr40");
      rd2(32'h40, 32'hDEADBEEF, "rd40");

      // held read: back-to-back transactions
      s2(1'b1, 1'b0, 32'h40, 0, BUSY,   32'h0,        "hold_b1");
      s2(1'b1, 1'b0, 32'h40, 0, BUSY,   32'h0,        "hold_b2");
      s2(1'b1, 1'b0, 32'h40, 0, ACCESS, 32'hDEADBEEF, "hold_a1");
      s2(1'b1, 1'b0, 32'h40, 0, BUSY,   32'h0,        "hold_b3");
      s2(1'b1, 1'b0, 32'h40, 0, BUSY,   32'h0,        "hold_b4");
      s2(1'b1, 1'b0, 32'h40, 0, ACCESS, 32'hDEADBEEF, "hold_a2");
      idle2("hold_idle");

      // address switch mid-write restarts; old address untouched
      wr2(32'h44, 32'h11111111, "pre44");
      s2(1'b0, 1'b1, 32'h44, 32'h5555, BUSY,   32'h0, "sw_b44");
      s2(1'b0, 1'b1, 32'h48, 32'h5555, BUSY,   32'h0, "sw_b48a");
      s2(1'b0, 1'b1, 32'h48, 32'h5555, BUSY,   32'h0, "sw_b48b");
      s2(1'b0, 1'b1, 32'h48, 32'h5555, ACCESS, 32'h0, "sw_acc");
      idle2("sw_idle");
      rd2(32'h44, 32'h11111111, "rd44");
      rd2(32'h48, 32'h00005555, "rd48");

      // error cases
      wr2(32'h10, 32'h10101010, "pre10");
      s2(1'b1, 1'b1, 32'h10, 32'hBAD, ERROR, 32'h0, "err_both");
      s2(1'b1, 1'b0, 32'h1000, 32'h0, ERROR, 32'h0, "err_oor");
      rd2(32'h40, 32'hDEADBEEF, "after_err");
      rd2(32'h10, 32'h10101010, "rd10");

      // reset abandons a pending write; array survives reset
      wr2(32'h80, 32'hCAFEF00D, "pre80");
      s2(1'b0, 1'b1, 32'h80, 32'h1234, BUSY, 32'h0, "rstw_b1");
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 32'h1234, BUSY, 32'h0, "rstw_rst");
      idle2("rstw_idle");
      rd2(32'h80, 32'hCAFEF00D, "rd80_old");
      wr2(32'h80, 32'h1234, "wr80");
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "rst_pulse");
      idle2("post_rst");
      rd2(32'h80, 32'h00001234, "rd80_keep");

      // LAT=0
      step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0C, 32'hA5A5A5A5, ACCESS, 32'h0, "l0_wr");
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0C, 32'h0, ACCESS, 32'hA5A5A5A5, "l0_rd1");
      step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0C, 32'h0, ACCESS, 32'hA5A5A5A5, "l0_rd2");
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "l0_idle");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
